// File: rtl/mean_filter_frame_ctrl.sv
// mean_filter_frame_ctrl
// Frame-level sequencer for the 3x3 gray mean-filter datapath.
// Tracks vsync/href/clken from the capture side, generates the per-pixel
// coordinates carried down the filter chain, owns the filter mode (host
// requests are committed only at a frame start), and optionally keeps
// frame statistics.
//
// Optional feature macro: FRAME_CTRL_STAT_EN
//   defined   : frame_cnt / geom_err logic is built
//   undefined : frame_cnt and geom_err are tied to 0, err_clr is ignored
//
// Ports
//   clk              pixel-pipeline clock
//   rst_n            asynchronous active-low reset
//   per_frame_vsync  frame valid, high during the frame
//   per_frame_href   line valid, high during the line
//   per_frame_clken  pixel strobe
//   cfg_mode[1:0]    requested mode (0 bypass, 1 mean, 2 mean w/o centre, 3 -> bypass)
//   cfg_valid        mode request strobe
//   cfg_ready        high when no request is pending
//   err_clr          clears geom_err
//   per_setx[10:0]   column index of the pixel under the current clken
//   per_sety[9:0]    row index of the current line
//   active_mode[1:0] mode in force for the current frame
//   frame_cnt[15:0]  completed-frame count
//   geom_err         sticky geometry error
module mean_filter_frame_ctrl #(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        err_clr,
  output logic [10:0] per_setx,
  output logic [9:0]  per_sety,
  output logic [1:0]  active_mode,
  output logic [15:0] frame_cnt,
  output logic        geom_err
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [10:0] X_MAX = 11'h7FF;
  localparam logic [9:0]  Y_MAX = 10'h3FF;

  state_t     state;
  state_t     state_nxt;
  logic       vsync_r;
  logic       href_r;
  logic       vs_rise;
  logic       vs_fall;
  logic       href_fall;
  logic       frame_start;
  logic       frame_end;
  logic       line_end;
  logic       pix_step;
  logic [1:0] pending_mode;

  assign vs_rise   = per_frame_vsync & ~vsync_r;
  assign vs_fall   = ~per_frame_vsync & vsync_r;
  assign href_fall = ~per_frame_href & href_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
    end else begin
      vsync_r <= per_frame_vsync;
      href_r  <= per_frame_href;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // SYNC drops whatever frame was in flight when reset released; only a
  // clean low-to-high vsync seen from WAIT opens a frame. Line and pixel
  // events are qualified here so nothing counts outside ACTIVE.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_end    = 1'b0;
    pix_step    = 1'b0;
    case (state)
      SYNC: begin
        if (!per_frame_vsync) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (vs_rise) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        line_end = href_fall;
        pix_step = per_frame_href & per_frame_clken;
        if (vs_fall) begin
          state_nxt = WAIT;
          frame_end = 1'b1;
        end
      end
      default: begin
        state_nxt = SYNC;
      end
    endcase
  end

  // A request taken in the same cycle as a frame start cannot also commit:
  // cfg_ready was still high, so nothing is pending yet and the new value
  // waits for the following frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready    <= 1'b1;
      pending_mode <= 2'd0;
      active_mode  <= 2'd1;
    end else begin
      if (cfg_valid && cfg_ready) begin
        pending_mode <= cfg_mode;
        cfg_ready    <= 1'b0;
      end else if (frame_start && !cfg_ready) begin
        active_mode <= (pending_mode == 2'd3) ? 2'd0 : pending_mode;
        cfg_ready   <= 1'b1;
      end
    end
  end

  // Both coordinates saturate rather than wrap so an oversized frame is
  // still flagged by the geometry check instead of aliasing to a legal size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_setx <= 11'd0;
      per_sety <= 10'd0;
    end else begin
      if (frame_start) begin
        per_setx <= 11'd0;
        per_sety <= 10'd0;
      end else if (line_end) begin
        per_setx <= 11'd0;
        if (per_sety != Y_MAX) begin
          per_sety <= per_sety + 10'd1;
        end
      end else if (pix_step && (per_setx != X_MAX)) begin
        per_setx <= per_setx + 11'd1;
      end
    end
  end

`ifdef FRAME_CTRL_STAT_EN
  localparam logic [10:0] HDISP = 11'(IMG_HDISP);
  localparam logic [9:0]  VDISP = 10'(IMG_VDISP);

  // At a line/frame end the coordinate registers still hold the count of
  // pixels/lines just completed, so they compare directly to the resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
      geom_err  <= 1'b0;
    end else begin
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if ((line_end && (per_setx != HDISP)) || (frame_end && (per_sety != VDISP))) begin
        geom_err <= 1'b1;
      end else if (err_clr) begin
        geom_err <= 1'b0;
      end
    end
  end
`else
  logic stat_unused;

  assign frame_cnt   = 16'd0;
  assign geom_err    = 1'b0;
  assign stat_unused = ^{err_clr, frame_end, 11'(IMG_HDISP), 10'(IMG_VDISP)};
`endif

endmodule
